// File: rtl/clk_enable_gen.sv
// ---------------------------------------------------------------------------
// clk_enable_gen
//
// Multi-channel clock-enable generator. Each channel divides the system
// clock by a runtime-programmable divisor and produces a one-cycle enable
// pulse (tick) at the end of every period plus a registered square wave
// (toggle) that inverts on every tick. Divisor writes are staged and only
// take effect at the channel's next terminal edge, so the period in flight
// always completes at the old divisor.
//
// Parameters
//   NUM_CH   number of independent divider channels (1..8)
//   DIV_W    divisor / counter width in bits
//   DEF_DIV  divisor loaded into every channel on reset
//
// Ports
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-high reset
//   en            global count enable
//   sync_restart  realign all channels to phase 0, apply pending divisors
//   div_wr        divisor write strobe
//   div_wr_ch     target channel of the write (out-of-range writes ignored)
//   div_wr_val    new divisor value (0 behaves as a divisor of 1)
//   tick          per-channel one-cycle enable pulse (registered)
//   toggle        per-channel square wave, period 2*P (registered)
//   all_tick      registered pulse when every channel ticks together
//   pend          per-channel divisor-write-pending flag
// ---------------------------------------------------------------------------
module clk_enable_gen #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_restart,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_wr_ch,
    input  logic [DIV_W-1:0]  div_wr_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] toggle,
    output logic              all_tick,
    output logic [NUM_CH-1:0] pend
);

    // Channel count widened by one bit so NUM_CH itself is representable
    // when comparing against the write address.
    localparam logic [CH_W:0]    NUM_CH_L  = (CH_W + 1)'(NUM_CH);
    localparam logic [DIV_W-1:0] DEF_DIV_L = DIV_W'(DEF_DIV);

    logic             wr_ok;
    logic [NUM_CH-1:0] term_hit;

    assign wr_ok = div_wr && ({1'b0, div_wr_ch} < NUM_CH_L);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [DIV_W-1:0] cnt;
            logic [DIV_W-1:0] active_div;
            logic [DIV_W-1:0] pend_div;
            logic             pend_valid;
            logic             tick_q;
            logic             toggle_q;
            logic [DIV_W-1:0] last_cnt;
            logic             terminal;
            logic             wr_hit;

            // Terminal count is P-1; a zero divisor is treated as P = 1,
            // which makes every enabled edge terminal.
            assign last_cnt = (active_div == '0) ? '0 : active_div - 1'b1;
            assign terminal = (cnt == last_cnt);
            assign wr_hit   = wr_ok && (div_wr_ch == CH_W'(i));

            assign term_hit[i] = en && terminal;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt        <= '0;
                    active_div <= DEF_DIV_L;
                    pend_div   <= '0;
                    pend_valid <= 1'b0;
                    tick_q     <= 1'b0;
                    toggle_q   <= 1'b0;
                end else if (sync_restart) begin
                    // A same-cycle write supersedes any older pending value.
                    cnt        <= '0;
                    tick_q     <= 1'b0;
                    toggle_q   <= 1'b0;
                    pend_valid <= 1'b0;
                    if (wr_hit) begin
                        active_div <= div_wr_val;
                    end else if (pend_valid) begin
                        active_div <= pend_div;
                    end
                end else if (en && terminal) begin
                    // End of period: the new divisor (write on this very
                    // edge first, else the staged one) governs the next one.
                    cnt        <= '0;
                    tick_q     <= 1'b1;
                    toggle_q   <= ~toggle_q;
                    pend_valid <= 1'b0;
                    if (wr_hit) begin
                        active_div <= div_wr_val;
                    end else if (pend_valid) begin
                        active_div <= pend_div;
                    end
                end else begin
                    tick_q <= 1'b0;
                    if (en) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Mid-period write is staged; last write wins.
                    if (wr_hit) begin
                        pend_div   <= div_wr_val;
                        pend_valid <= 1'b1;
                    end
                end
            end

            assign tick[i]   = tick_q;
            assign toggle[i] = toggle_q;
            assign pend[i]   = pend_valid;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_tick <= 1'b0;
        end else begin
            all_tick <= !sync_restart && (&term_hit);
        end
    end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 2, SHALL set the number of independent divider channels (1..8).
REQ-002 Parameter DIV_W, default 8, SHALL set the divisor width in bits.
REQ-003 Parameter DEF_DIV, default 4, SHALL set the reset divisor of every channel.
REQ-004 Port clk, input, 1: the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port en, input, 1: global count enable.
REQ-007 Port sync_restart, input, 1: realign all channels to phase 0.
REQ-008 Port div_wr, input, 1: divisor write strobe.
REQ-009 Port div_wr_ch, input, $clog2(NUM_CH) (min 1): target channel of the write.
REQ-010 Port div_wr_val, input, DIV_W: new divisor value.
REQ-011 Port tick, output, NUM_CH: per-channel one-cycle enable pulse, registered.
REQ-012 Port toggle, output, NUM_CH: per-channel square wave, registered.
REQ-013 Port all_tick, output, 1: registered pulse when every channel ticks on the same cycle.
REQ-014 Port pend, output, NUM_CH: per-channel "divisor write pending" flag.

Function
REQ-015 Each channel SHALL hold cnt (DIV_W bits), active_div, pend_div and pend_valid registers.
REQ-016 Effective period P SHALL be active_div, except active_div = 0 SHALL be treated as P = 1.
REQ-017 With en=1 and no sync_restart: if cnt == P-1, cnt <= 0 and tick[i] <= 1; otherwise cnt <= cnt+1 and tick[i] <= 0.
REQ-018 With en=0: cnt and toggle SHALL hold and tick SHALL be 0 on the next cycle.
REQ-019 toggle[i] SHALL invert on the same edge that sets tick[i]; toggle period is 2P cycles.
REQ-020 all_tick SHALL be set on the edge where every channel sets tick, else cleared.
REQ-021 div_wr with div_wr_ch < NUM_CH: pend_div <= div_wr_val and pend_valid <= 1; div_wr_ch >= NUM_CH SHALL be ignored.
REQ-022 A pending divisor SHALL load into active_div on the channel's next terminal edge (cnt == P-1 with en=1); pend_valid then clears; the current period always completes at the old divisor.
REQ-023 A write coinciding with the channel's terminal edge SHALL load directly into active_div; pend_valid stays 0.
REQ-024 A second write before apply SHALL overwrite pend_div (last write wins).
REQ-025 sync_restart=1 SHALL take priority over en: all cnt <= 0, all toggle <= 0, tick and all_tick <= 0, all pending divisors applied immediately, pend cleared.
REQ-026 A div_wr in the same cycle as sync_restart SHALL be applied as the new active_div.
REQ-027 pend[i] SHALL equal pend_valid[i].
REQ-028 A divisor change SHALL never produce a tick spacing other than the old P (for the period in flight) or the new P (afterwards).

Reset
REQ-029 On rst=1, asynchronously: cnt = 0, active_div = DEF_DIV, pend_div = 0, pend_valid = 0, tick = 0, toggle = 0, all_tick = 0.
REQ-030 Deassertion of rst mid-period SHALL restart every channel at cnt = 0; the first tick is visible after the P-th enabled edge.

Verification
REQ-031 Reset release, en=1, defaults (NUM_CH=2, DEF_DIV=4) -> tick on both channels every 4 cycles; first tick after edge 4; all_tick coincident; toggle period 8.
REQ-032 Write ch1=10 while ch1 cnt=1 -> pend[1]=1; two more ticks at spacing 4 are not produced; the tick at old terminal comes at spacing 4, then spacing 10; pend[1] clears on the apply edge.
REQ-033 Write ch0=0, then ch0=1 -> tick[0] every cycle in both cases; toggle[0] alternates each cycle.
REQ-034 en low for 3 cycles mid-period at cnt=2 -> no ticks, cnt holds at 2; after en returns, the tick arrives 2 enabled edges later.
REQ-035 ch0=3, ch1=5, sync_restart pulse plus div_wr ch1=6 in the same cycle -> all outputs 0, ch1 active_div=6; ticks at 3 and 6 cycles later; all_tick at 6, 12.
REQ-036 div_wr_ch=3 with NUM_CH=2 -> no state change; rst asserted mid-count -> all outputs 0 immediately, without waiting for a clk edge.
